// File: rtl/uart_defs.sv
// Shared UART definitions: transmitter FSM encoding, default bit timing and frame shape.
// The receive-side bench model reuses these constants.
package uart_defs;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam int CLKS_PER_BIT_DEFAULT = 434;
   localparam int DATA_BITS            = 8;
   localparam int STOP_BITS            = 1;
   localparam int BAUD_CNT_W           = 16;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; read data is the head entry, visible combinationally.
// Push while full and pop while empty are ignored; wrap is modulo DEPTH (power of two).
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a byte queued while idle drives the start bit one cycle later.
// in_ready falls when the FIFO is full; the source holds its byte until accepted.
module uart_tx_fifo
   import uart_defs::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          Clk,
   input  logic                          reset_rtl,
   input  logic [7:0]                    in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic                          txd,
   output logic                          tx_busy,
   output logic                          tx_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam logic [BAUD_CNT_W-1:0] BIT_LAST  = BAUD_CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]            DATA_LAST = 3'(DATA_BITS - 1);
   localparam logic [2:0]            STOP_LAST = 3'(STOP_BITS - 1);

   tx_state_t             state, state_nxt;
   logic [BAUD_CNT_W-1:0] baud_cnt, baud_nxt;
   logic [2:0]            bit_idx, bit_nxt;
   logic [7:0]            shreg, shreg_nxt;
   logic                  txd_nxt;
   logic                  bit_end;
   logic                  pop;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [7:0]            head;

   assign in_ready = !fifo_full;
   assign tx_busy  = (state != IDLE);
   assign bit_end  = (baud_cnt == BIT_LAST);

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (Clk),
      .rst_n     (reset_rtl),
      .push      (in_valid && in_ready),
      .push_data (in_data),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_comb begin
      state_nxt = state;
      baud_nxt  = baud_cnt + BAUD_CNT_W'(1);
      bit_nxt   = bit_idx;
      shreg_nxt = shreg;
      txd_nxt   = txd;
      pop       = 1'b0;
      tx_done   = 1'b0;
      case (state)
         IDLE: begin
            baud_nxt = '0;
            txd_nxt  = 1'b1;
            if (!fifo_empty) begin
               pop       = 1'b1;
               shreg_nxt = head;
               bit_nxt   = '0;
               txd_nxt   = 1'b0;
               state_nxt = START;
            end
         end
         START: begin
            if (bit_end) begin
               baud_nxt  = '0;
               txd_nxt   = shreg[0];
               state_nxt = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_nxt = '0;
               if (bit_idx == DATA_LAST) begin
                  bit_nxt   = '0;
                  txd_nxt   = 1'b1;
                  state_nxt = STOP;
               end else begin
                  // Shift so the next bit to send is always shreg[0] on entry.
                  bit_nxt   = bit_idx + 3'd1;
                  shreg_nxt = shreg >> 1;
                  txd_nxt   = shreg[1];
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               baud_nxt = '0;
               if (bit_idx == STOP_LAST) begin
                  tx_done   = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  bit_nxt = bit_idx + 3'd1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge reset_rtl) begin
      if (!reset_rtl) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         txd      <= 1'b1;
      end else begin
         state    <= state_nxt;
         baud_cnt <= baud_nxt;
         bit_idx  <= bit_nxt;
         shreg    <= shreg_nxt;
         txd      <= txd_nxt;
      end
   end

endmodule
